wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//  Write-back merge queue directly upstream of the register file. It merges two
//  write sources into the register file's single write port: the in-order
//  pipeline (MEM/WB, source A) and the long-latency unit returns (mul/div, load
//  miss, source B). Pending writes are buffered in order and drained one per cycle.
//  Pending data is forwarded to both ID read ports, because the register file
//  only bypasses the write it is doing in the current cycle.
// PARAMETERS
//  DEPTH   4   queue entries (power of 2, >=4)
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  a_we_i     in   1       source A write valid
//  a_waddr_i  in   ADDR_W  source A destination register
//  a_wdata_i  in   DATA_W  source A data
//  b_we_i     in   1       source B write valid
//  b_waddr_i  in   ADDR_W  source B destination register
//  b_wdata_i  in   DATA_W  source B data
//  we_o       out  1       to regfile write enable
//  waddr_o    out  ADDR_W  to regfile write address
//  wdata_o    out  DATA_W  to regfile write data
//  raddr1_i   in   ADDR_W  ID read port 1 address (lookup)
//  raddr2_i   in   ADDR_W  ID read port 2 address (lookup)
//  hit1_o     out  1       port 1 address matches a pending entry
//  fdata1_o   out  DATA_W  forwarded data for port 1 (0 when no hit)
//  hit2_o     out  1       port 2 address matches a pending entry
//  fdata2_o   out  DATA_W  forwarded data for port 2 (0 when no hit)
//  stall_o    out  1       upstream must not present valid writes
//  overflow_o out  1       sticky: a write was dropped for lack of space
// BEHAVIOUR
//  - Storage is a circular buffer: rd_ptr, wr_ptr, count (0..DEPTH). Pointers wrap modulo DEPTH.
//  - Reset (rst=0, async): ptrs/count/overflow cleared. All outputs are 0.
//  - Writes to register 0 are discarded at enqueue and never occupy an entry.
//  - Dequeue: deq = (count!=0). we_o/waddr_o/wdata_o come combinationally from the head entry.
//    When empty they are all 0. The head is popped on every rising edge where deq=1.
//  - Enqueue at a rising edge: space = DEPTH - count + deq.
//    A is written before B, so A is older in queue order.
//    If A and B are both valid, both are accepted only when space>=2. Otherwise A is kept and B is dropped.
//  - Any dropped valid nonzero-address write sets overflow_o, which holds until reset.
//  - Next count is count + accepted - deq.
//  - Latency: a write presented at edge N appears on we_o during cycle N+1 if the queue was empty.
//  - stall_o = (count >= DEPTH-1), combinational from count. Upstream holds both sources while it is 1.
//  - Forwarding (combinational): search all valid entries.
//    Raddr 0 never hits. The youngest matching entry wins, including the head being drained.
//    The same rules apply independently to port 2.
//  - Incoming A/B writes in the current cycle are NOT forwarded here (the EX/MEM bypass covers them).
// TESTING
//  1 A writes r3=0x0000_00AA -> next cycle we_o=1 waddr_o=3 wdata_o=0xAA; following cycle we_o=0
//  2 Same cycle A r4=0x44, B r5=0x55 -> we_o: r4/0x44 then r5/0x55 on consecutive cycles
//  3 Queue holds r6=0x11 then r6=0x22, raddr1_i=6 -> hit1_o=1 fdata1_o=0x22; raddr2_i=0 -> hit2_o=0
//  4 A writes r0=0xFFFF_FFFF -> we_o stays 0, count stays 0, overflow_o=0
//  5 Dual writes on 2 consecutive edges from empty -> count 2 then 3, stall_o=1 after edge 2.
//    A 3rd dual write is forced in -> space=2, so both are accepted and overflow_o stays 0.
//    A 4th forced dual write when space=1 -> B dropped, overflow_o=1
//  6 rst pulsed low mid-drain with count=3 -> we_o/hit/stall/overflow all 0 immediately.
//    After release the queue is empty.

Source files
------------

// File: rtl/wb_write_queue.sv
// Write-back merge queue: in-order buffer that merges pipeline (A) and long-latency (B)
// writes into the single register-file write port and forwards pending data to ID reads.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_waddr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_waddr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              hit1_o,
    output logic [DATA_W-1:0] fdata1_o,
    output logic              hit2_o,
    output logic [DATA_W-1:0] fdata2_o,
    output logic              stall_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic              deq_s;
    logic              a_v_s;
    logic              b_v_s;
    logic              acc_a_s;
    logic              acc_b_s;
    logic              drop_s;
    logic [CNT_W-1:0]  space_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [PTR_W-1:0]  b_ptr_s;

    // Enqueue admission: register-0 writes vanish, A has priority, B needs a second slot.
    always_comb begin
        deq_s   = (count_r != {CNT_W{1'b0}});
        a_v_s   = a_we_i && (a_waddr_i != {ADDR_W{1'b0}});
        b_v_s   = b_we_i && (b_waddr_i != {ADDR_W{1'b0}});
        space_s = CNT_W'(DEPTH) - count_r + {{(CNT_W-1){1'b0}}, deq_s};
        acc_a_s = a_v_s && (space_s != {CNT_W{1'b0}});
        acc_b_s = b_v_s && (a_v_s ? (space_s >= CNT_W'(2)) : (space_s != {CNT_W{1'b0}}));
        drop_s  = (a_v_s && !acc_a_s) || (b_v_s && !acc_b_s);
        b_ptr_s = acc_a_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, acc_a_s} + {{(CNT_W-1){1'b0}}, acc_b_s}
                      - {{(CNT_W-1){1'b0}}, deq_s};
    end

    // Head presentation, stall and youngest-match forwarding for both read ports.
    always_comb begin
        we_o       = deq_s;
        waddr_o    = deq_s ? addr_mem_r[rd_ptr_r] : {ADDR_W{1'b0}};
        wdata_o    = deq_s ? data_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
        stall_o    = (count_r >= CNT_W'(DEPTH - 1));
        overflow_o = overflow_r;
        hit1_o     = 1'b0;
        fdata1_o   = {DATA_W{1'b0}};
        hit2_o     = 1'b0;
        fdata2_o   = {DATA_W{1'b0}};
        // Walk oldest to youngest so the last match wins.
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            logic             live;
            logic             m1;
            logic             m2;
            idx      = rd_ptr_r + PTR_W'(i);
            live     = (CNT_W'(i) < count_r);
            m1       = live && (raddr1_i != {ADDR_W{1'b0}}) && (addr_mem_r[idx] == raddr1_i);
            m2       = live && (raddr2_i != {ADDR_W{1'b0}}) && (addr_mem_r[idx] == raddr2_i);
            hit1_o   = m1 ? 1'b1 : hit1_o;
            fdata1_o = m1 ? data_mem_r[idx] : fdata1_o;
            hit2_o   = m2 ? 1'b1 : hit2_o;
            fdata2_o = m2 ? data_mem_r[idx] : fdata2_o;
        end
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            rd_ptr_r   <= deq_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
            wr_ptr_r   <= wr_ptr_r + {{(PTR_W-1){1'b0}}, acc_a_s} + {{(PTR_W-1){1'b0}}, acc_b_s};
            count_r    <= count_nxt_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc_a_s) begin
            addr_mem_r[wr_ptr_r] <= a_waddr_i;
            data_mem_r[wr_ptr_r] <= a_wdata_i;
        end
        if (acc_b_s) begin
            addr_mem_r[b_ptr_s] <= b_waddr_i;
            data_mem_r[b_ptr_s] <= b_wdata_i;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: expected regfile writes go into a scoreboard queue
// that a negedge monitor drains; occupancy/forwarding flags are checked inline.
module tb_wb_write_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_we_i = 1'b0, b_we_i = 1'b0;
    logic [4:0]  a_waddr_i = 5'd0, b_waddr_i = 5'd0;
    logic [31:0] a_wdata_i = 32'd0, b_wdata_i = 32'd0;
    logic        we_o, hit1_o, hit2_o, stall_o, overflow_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, fdata1_o, fdata2_o;
    logic [4:0]  raddr1_i = 5'd0, raddr2_i = 5'd0;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q [$];

    wb_write_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_we_i(a_we_i), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
        .b_we_i(b_we_i), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
        .hit1_o(hit1_o), .fdata1_o(fdata1_o), .hit2_o(hit2_o), .fdata2_o(fdata2_o),
        .stall_o(stall_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_we_i = av; a_waddr_i = aa; a_wdata_i = ad;
        b_we_i = bv; b_waddr_i = ba; b_wdata_i = bd;
        tick();
        a_we_i = 1'b0;
        b_we_i = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && we_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got r%0d=0x%08h, want no write", waddr_o, wdata_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(waddr_o), 32'(e[36:32]));
                chk("wb_data", wdata_o, e[31:0]);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        #10;
        rst = 1'b1;
        tick();

        // 1: single A write, one-cycle latency
        expect_wr(5'd3, 32'h0000_00AA);
        drive(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
        chk("t1_we_high", 32'(we_o), 32'd1);
        tick();
        chk("t1_we_low", 32'(we_o), 32'd0);

        // 2: same-cycle A and B, A drains first
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd5, 32'h55);
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
        chk("t2_we_first", 32'(we_o), 32'd1);
        tick();
        chk("t2_we_second", 32'(we_o), 32'd1);
        tick();
        chk("t2_we_low", 32'(we_o), 32'd0);

        // 3: forwarding, youngest entry wins, r0 never hits
        expect_wr(5'd6, 32'h11);
        expect_wr(5'd6, 32'h22);
        drive(1'b1, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22);
        raddr1_i = 5'd6; raddr2_i = 5'd0;
        #1;
        chk("t3_hit1", 32'(hit1_o), 32'd1);
        chk("t3_fdata1", fdata1_o, 32'h22);
        chk("t3_hit2_r0", 32'(hit2_o), 32'd0);
        chk("t3_fdata2_r0", fdata2_o, 32'd0);
        tick();
        raddr2_i = 5'd7;
        #1;
        chk("t3_hit1_head", 32'(hit1_o), 32'd1);
        chk("t3_fdata1_head", fdata1_o, 32'h22);
        chk("t3_hit2_miss", 32'(hit2_o), 32'd0);
        tick();
        chk("t3_hit1_empty", 32'(hit1_o), 32'd0);
        chk("t3_fdata1_empty", fdata1_o, 32'd0);
        raddr1_i = 5'd0; raddr2_i = 5'd0;

        // 4: writes to r0 are discarded
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        chk("t4_we", 32'(we_o), 32'd0);
        chk("t4_stall", 32'(stall_o), 32'd0);
        chk("t4_ovf", 32'(overflow_o), 32'd0);

        // 5: fill to stall, accepted dual at space=2, drop at space=1
        expect_wr(5'd1, 32'h1);  expect_wr(5'd2, 32'h2);
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        chk("t5_stall_c2", 32'(stall_o), 32'd0);
        expect_wr(5'd7, 32'h7);  expect_wr(5'd8, 32'h8);
        drive(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
        chk("t5_stall_c3", 32'(stall_o), 32'd1);
        expect_wr(5'd9, 32'h9);  expect_wr(5'd10, 32'hA);
        drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
        chk("t5_ovf_space2", 32'(overflow_o), 32'd0);
        chk("t5_stall_c4", 32'(stall_o), 32'd1);
        expect_wr(5'd11, 32'hB);
        drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
        chk("t5_ovf_space1", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        tick();
        chk("t5_ovf_sticky", 32'(overflow_o), 32'd1);

        // 6: async reset mid-drain with count=3
        expect_wr(5'd13, 32'h13); expect_wr(5'd14, 32'h14);
        drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14);
        expect_wr(5'd15, 32'h15); expect_wr(5'd16, 32'h16);
        drive(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16);
        raddr1_i = 5'd15;
        #1;
        chk("t6_stall_pre", 32'(stall_o), 32'd1);
        chk("t6_hit1_pre", 32'(hit1_o), 32'd1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_we", 32'(we_o), 32'd0);
        chk("t6_waddr", 32'(waddr_o), 32'd0);
        chk("t6_stall", 32'(stall_o), 32'd0);
        chk("t6_ovf", 32'(overflow_o), 32'd0);
        chk("t6_hit1", 32'(hit1_o), 32'd0);
        chk("t6_fdata1", fdata1_o, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        chk("t6_we_after", 32'(we_o), 32'd0);
        chk("t6_hit1_after", 32'(hit1_o), 32'd0);
        expect_wr(5'd20, 32'h0000_C0DE);
        drive(1'b1, 5'd20, 32'h0000_C0DE, 1'b0, 5'd0, 32'd0);
        chk("t6_we_restart", 32'(we_o), 32'd1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
